// File: rtl/execute_mdu_pkg.sv
// Shared types for the execute stage: ALU opcode encoding, FSM states and
// the divide-by-zero result policy used by the iterative mul/div unit.
// No ports; imported by the interface, the iterator and the top level.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_MUL  = 4'd7,
    OP_MULH = 4'd8,
    OP_DIVU = 4'd9,
    OP_REMU = 4'd10
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // x/0 yields a quotient filled with this bit value (all-ones).
  localparam logic DIV0_QUOT_FILL    = 1'b1;
  // x%0 yields the dividend unchanged when set, zero otherwise.
  localparam bit   DIV0_REM_DIVIDEND = 1'b1;

  // Ops that go through the iterative unit instead of the single-cycle ALU.
  function automatic logic is_multi(alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/execute_mdu_if.sv
// Decode-facing bus of the execute stage: issue handshake, operands,
// forwarding sources and the registered result.
// master = decode/pipeline side, slave = execute stage.
interface execute_mdu_if
  import exec_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3
);
  logic                in_valid;
  logic                in_ready;
  logic                flush;
  alu_op_e             alu_op;
  logic                use_imm;
  logic [REG_BITS-1:0] s_1;
  logic [REG_BITS-1:0] s_2;
  logic [REG_BITS-1:0] tgt;
  logic [WIDTH-1:0]    imm;
  logic [WIDTH-1:0]    reg_out_1;
  logic [WIDTH-1:0]    reg_out_2;
  logic [REG_BITS-1:0] mem_tgt;
  logic [REG_BITS-1:0] wb_tgt;
  logic [WIDTH-1:0]    mem_result;
  logic [WIDTH-1:0]    wb_result;
  logic                out_valid;
  logic [WIDTH-1:0]    out_result;
  logic [REG_BITS-1:0] out_tgt;

  modport master (
    output in_valid, flush, alu_op, use_imm, s_1, s_2, tgt, imm,
           reg_out_1, reg_out_2, mem_tgt, wb_tgt, mem_result, wb_result,
    input  in_ready, out_valid, out_result, out_tgt
  );

  modport slave (
    input  in_valid, flush, alu_op, use_imm, s_1, s_2, tgt, imm,
           reg_out_1, reg_out_2, mem_tgt, wb_tgt, mem_result, wb_result,
    output in_ready, out_valid, out_result, out_tgt
  );
endinterface

// File: rtl/execute_mdu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Latency: WIDTH cycles after start; done is asserted combinationally in the last one.
// Backpressure: none; caller must not start while busy. abort kills the run.
// Ports: clk, rst (sync, high), start/op/a/b load, abort, busy, done, result.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);

  // hi/lo form one 2*WIDTH shift register: product for multiply,
  // {remainder, dividend/quotient} for divide.
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] div_q, div_d;   // multiplicand or divisor
  logic [WIDTH-1:0] a_q, a_d;       // original dividend for x%0
  logic             dz_q, dz_d;
  alu_op_e          op_q, op_d;

  logic [WIDTH:0]   msum, rs, rdiff;
  logic             ge, is_mul;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign busy = (cnt_q != '0);
  assign done = busy && (cnt_q == CW'(1));
  assign is_mul = (op_q == OP_MUL) || (op_q == OP_MULH);

  always_comb begin
    // Multiply: add multiplicand into the upper half when the LSB is set,
    // then shift the whole register right (carry enters the top).
    msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, div_q} : '0);
    // Divide: shift next dividend bit into the partial remainder and
    // subtract the divisor if it fits.
    rs    = {hi_q, lo_q[WIDTH-1]};
    ge    = (rs >= {1'b0, div_q});
    rdiff = rs - {1'b0, div_q};
    if (is_mul) begin
      step_hi = msum[WIDTH:1];
      step_lo = {msum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = ge ? rdiff[WIDTH-1:0] : rs[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ge};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    div_d = div_q;
    a_d   = a_q;
    dz_d  = dz_q;
    op_d  = op_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = CW'(WIDTH);
      op_d  = op;
      a_d   = a;
      dz_d  = (b == '0);
      hi_d  = '0;
      if ((op == OP_MUL) || (op == OP_MULH)) begin
        lo_d  = b;
        div_d = a;
      end else begin
        lo_d  = a;
        div_d = b;
      end
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
      hi_d  = step_hi;
      lo_d  = step_lo;
    end
  end

  // Result is taken from the step being completed this cycle.
  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:  result = step_lo;
      OP_MULH: result = step_hi;
      OP_DIVU: result = dz_q ? {WIDTH{DIV0_QUOT_FILL}} : step_lo;
      OP_REMU: result = dz_q ? (DIV0_REM_DIVIDEND ? a_q : '0) : step_hi;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      div_q <= '0;
      a_q   <= '0;
      dz_q  <= 1'b0;
      op_q  <= OP_ADD;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      div_q <= div_d;
      a_q   <= a_d;
      dz_q  <= dz_d;
      op_q  <= op_d;
    end
  end
endmodule

// File: rtl/execute_mdu.sv
// Execute stage: forwarding muxes, single-cycle ALU, iterative mul/div, registered result.
// Latency: 1 cycle for ALU ops, WIDTH+1 cycles for MUL/MULH/DIVU/REMU.
// Backpressure: in_ready drops while the iterator runs; no backpressure downstream.
// Ports: clk, rst (sync, high), bus (execute_mdu_if.slave).
module execute_mdu
  import exec_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  execute_mdu_if.slave bus
);
  localparam int SH_BITS = $clog2(WIDTH);

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_result_q, out_result_d;
  logic [REG_BITS-1:0] out_tgt_q, out_tgt_d;
  logic [REG_BITS-1:0] pend_tgt_q, pend_tgt_d;  // target of the op in the iterator

  logic             accept, multi;
  logic [WIDTH-1:0] lhs, src2, rhs, alu_res;
  logic             iter_busy, iter_done;
  logic [WIDTH-1:0] iter_result;

  assign bus.in_ready   = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tgt    = out_tgt_q;

  assign accept = bus.in_valid && bus.in_ready && !bus.flush;
  assign multi  = is_multi(bus.alu_op);

  // Forwarding: own result, then MEM, then WB, then register file.
  // Register 0 always reads the register file.
  always_comb begin
    lhs = bus.reg_out_1;
    if (bus.s_1 != '0) begin
      if (out_valid_q && (out_tgt_q == bus.s_1)) lhs = out_result_q;
      else if (bus.mem_tgt == bus.s_1)           lhs = bus.mem_result;
      else if (bus.wb_tgt == bus.s_1)            lhs = bus.wb_result;
    end
  end

  always_comb begin
    src2 = bus.reg_out_2;
    if (bus.s_2 != '0) begin
      if (out_valid_q && (out_tgt_q == bus.s_2)) src2 = out_result_q;
      else if (bus.mem_tgt == bus.s_2)           src2 = bus.mem_result;
      else if (bus.wb_tgt == bus.s_2)            src2 = bus.wb_result;
    end
  end

  assign rhs = bus.use_imm ? bus.imm : src2;

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      OP_ADD:  alu_res = lhs + rhs;
      OP_SUB:  alu_res = lhs - rhs;
      OP_AND:  alu_res = lhs & rhs;
      OP_OR:   alu_res = lhs | rhs;
      OP_XOR:  alu_res = lhs ^ rhs;
      OP_SHL:  alu_res = lhs << rhs[SH_BITS-1:0];
      OP_SHR:  alu_res = lhs >> rhs[SH_BITS-1:0];
      default: alu_res = '0;  // iterative ops and unused codes
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && multi),
    .abort  (bus.flush),
    .op     (bus.alu_op),
    .a      (lhs),
    .b      (rhs),
    .busy   (iter_busy),
    .done   (iter_done),
    .result (iter_result)
  );

  always_comb begin
    state_d      = state_q;
    out_valid_d  = 1'b0;
    out_tgt_d    = '0;
    out_result_d = out_result_q;
    pend_tgt_d   = pend_tgt_q;
    if (bus.flush) begin
      // Kills both the presented and any in-flight instruction.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (multi) begin
              state_d    = ST_BUSY;
              pend_tgt_d = bus.tgt;
            end else begin
              out_valid_d  = 1'b1;
              out_result_d = alu_res;
              out_tgt_d    = bus.tgt;
            end
          end
        end
        ST_BUSY: begin
          if (iter_done) begin
            out_valid_d  = 1'b1;
            out_result_d = iter_result;
            out_tgt_d    = pend_tgt_q;
            state_d      = ST_IDLE;
          end else if (!iter_busy) begin
            state_d = ST_IDLE;  // iterator lost its run; never wedge
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tgt_q    <= '0;
      pend_tgt_q   <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tgt_q    <= out_tgt_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end
endmodule

// File: tb/tb_execute_mdu.sv
// Self-checking bench for execute_mdu (WIDTH=16, REG_BITS=3): directed cases
// plus randomized back-to-back ops against an arithmetic reference model.
module tb_execute_mdu;
  import exec_pkg::*;

  localparam int W  = 16;
  localparam int RB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_mdu_if #(.WIDTH(W), .REG_BITS(RB)) bus ();
  execute_mdu #(.WIDTH(W), .REG_BITS(RB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic modulo 2^W.
  function automatic logic [W-1:0] ref_alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ua, ub, p;
    ua = 64'(a);
    ub = 64'(b);
    p  = ua * ub;
    case (op)
      0:  return W'(ua + ub);
      1:  return W'(ua - ub);
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return W'(ua << (ub % W));
      6:  return W'(ua >> (ub % W));
      7:  return W'(p);
      8:  return W'(p >> W);
      9:  return (ub == 0) ? {W{1'b1}} : W'(ua / ub);
      10: return (ub == 0) ? a : W'(ua % ub);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_fwd(input int s, input logic [W-1:0] rf,
      input bit pv, input int pt, input logic [W-1:0] pr,
      input int mt, input logic [W-1:0] mr, input int wt, input logic [W-1:0] wr);
    if (s == 0) return rf;
    if (pv && pt == s) return pr;
    if (mt == s) return mr;
    if (wt == s) return wr;
    return rf;
  endfunction

  task automatic present(input int op, input int s1, input int s2, input int tgt,
      input bit ui, input logic [W-1:0] imm, input logic [W-1:0] r1, input logic [W-1:0] r2,
      input int mt, input logic [W-1:0] mr, input int wt, input logic [W-1:0] wr);
    bus.alu_op     = alu_op_e'(op[3:0]);
    bus.s_1        = RB'(s1);
    bus.s_2        = RB'(s2);
    bus.tgt        = RB'(tgt);
    bus.use_imm    = ui;
    bus.imm        = imm;
    bus.reg_out_1  = r1;
    bus.reg_out_2  = r2;
    bus.mem_tgt    = RB'(mt);
    bus.mem_result = mr;
    bus.wb_tgt     = RB'(wt);
    bus.wb_result  = wr;
  endtask

  // Called at a negedge: issue the presented op, scramble operand data after
  // the accept edge, then wait for the result (lat = 0 on timeout).
  task automatic run(output logic [W-1:0] res, output int otgt, output int lat, output int lo_rdy);
    res = '0; otgt = 0; lat = 0; lo_rdy = 0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus.reg_out_1  = W'($urandom);
    bus.reg_out_2  = W'($urandom);
    bus.imm        = W'($urandom);
    bus.mem_result = W'($urandom);
    bus.wb_result  = W'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!bus.in_ready) lo_rdy++;
      if (bus.out_valid) begin
        lat  = k;
        res  = bus.out_result;
        otgt = int'(bus.out_tgt);
        break;
      end
    end
  endtask

  // Count out_valid pulses over n cycles.
  task automatic watch(input int n, output int vcnt);
    vcnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.out_valid) vcnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic [W-1:0] res, exp_res, a_op, b_op, pr;
  int t, lat, lo, vc, op, s1, s2, tg, mt, wt, pt;
  logic [W-1:0] r1, r2, imm, mr, wr;
  bit ui, pv;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    present(0, 0, 0, 0, 0, '0, '0, '0, 0, '0, 0, '0);

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_tgt", 32'(bus.out_tgt), 32'd0);
    check("rst_result", 32'(bus.out_result), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);

    // MUL / MULH 300*300, back-to-back
    present(7, 1, 2, 5, 0, '0, 16'd300, 16'd300, 0, '0, 0, '0);
    run(res, t, lat, lo);
    check("mul_res", 32'(res), 32'h5F90);
    check("mul_tgt", 32'(t), 32'd5);
    check("mul_lat", 32'(lat), 32'd17);
    check("mul_rdy_low", 32'(lo), 32'd16);
    present(8, 1, 2, 6, 0, '0, 16'd300, 16'd300, 0, '0, 0, '0);
    run(res, t, lat, lo);
    check("mulh_res", 32'(res), 32'h0001);
    check("mulh_lat", 32'(lat), 32'd17);

    // DIVU / REMU, including divide by zero
    present(9, 1, 2, 3, 0, '0, 16'd100, 16'd7, 0, '0, 0, '0);
    run(res, t, lat, lo);
    check("divu_res", 32'(res), 32'd14);
    check("divu_lat", 32'(lat), 32'd17);
    present(10, 1, 2, 3, 0, '0, 16'd100, 16'd7, 0, '0, 0, '0);
    run(res, t, lat, lo);
    check("remu_res", 32'(res), 32'd2);
    present(9, 1, 2, 3, 0, '0, 16'h1234, 16'h0000, 0, '0, 0, '0);
    run(res, t, lat, lo);
    check("divu0_res", 32'(res), 32'hFFFF);
    present(10, 1, 0, 3, 1, 16'h0000, 16'h1234, 16'h5555, 0, '0, 0, '0);
    run(res, t, lat, lo);
    check("remu0_res", 32'(res), 32'h1234);

    // Forwarding
    @(negedge clk);
    present(0, 4, 5, 1, 0, '0, 16'd5, 16'd3, 0, '0, 0, '0);
    run(res, t, lat, lo);
    check("fwd_add_base", 32'(res), 32'd8);
    check("fwd_add_lat", 32'(lat), 32'd1);
    present(0, 1, 0, 2, 1, 16'd1, 16'h0077, '0, 0, '0, 0, '0);
    run(res, t, lat, lo);
    check("fwd_own", 32'(res), 32'd9);
    present(0, 3, 0, 0, 1, 16'd0, 16'h0099, '0, 3, 16'h0011, 3, 16'h0022);
    run(res, t, lat, lo);
    check("fwd_mem_prio", 32'(res), 32'h0011);
    present(0, 0, 0, 0, 1, 16'd0, 16'h0042, '0, 0, 16'h0055, 0, 16'h0066);
    run(res, t, lat, lo);
    check("fwd_zero_reg", 32'(res), 32'h0042);
    present(0, 3, 0, 4, 1, 16'd0, 16'h0099, '0, 2, 16'h0011, 3, 16'h0022);
    run(res, t, lat, lo);
    check("fwd_wb", 32'(res), 32'h0022);

    // Flush 5 cycles into a MUL
    @(negedge clk);
    present(7, 1, 2, 4, 0, '0, 16'd9, 16'd9, 0, '0, 0, '0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    watch(5, vc);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_ready", 32'(bus.in_ready), 32'd1);
    check("flush_tgt", 32'(bus.out_tgt), 32'd0);
    if (bus.out_valid) vc++;
    watch(20, t);
    check("flush_no_valid", 32'(vc + t), 32'd0);
    present(0, 4, 5, 6, 0, '0, 16'd20, 16'd22, 0, '0, 0, '0);
    run(res, t, lat, lo);
    check("post_flush_add", 32'(res), 32'd42);
    check("post_flush_lat", 32'(lat), 32'd1);

    // Flush in the completion cycle of a MUL
    @(negedge clk);
    present(7, 1, 2, 4, 0, '0, 16'd3, 16'd3, 0, '0, 0, '0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    watch(16, vc);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    watch(20, t);
    check("flush_last_no_valid", 32'(vc + t), 32'd0);
    check("flush_last_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a DIVU
    present(9, 1, 2, 5, 0, '0, 16'd1000, 16'd3, 0, '0, 0, '0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    watch(3, vc);
    rst = 1'b1;
    #1;
    check("rst_mid_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_result", 32'(bus.out_result), 32'd0);
    check("rst_mid_tgt", 32'(bus.out_tgt), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    watch(20, t);
    check("rst_mid_no_valid", 32'(vc + t), 32'd0);

    // Unused opcode 13
    present(13, 4, 5, 3, 0, '0, 16'h1234, 16'd5, 0, '0, 0, '0);
    run(res, t, lat, lo);
    check("op13_res", 32'(res), 32'd0);
    check("op13_lat", 32'(lat), 32'd1);
    check("op13_tgt", 32'(t), 32'd3);

    // flush together with in_valid: nothing accepted
    @(negedge clk);
    present(0, 4, 5, 2, 0, '0, 16'd1, 16'd1, 0, '0, 0, '0);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    watch(20, vc);
    check("flush_issue_no_valid", 32'(vc), 32'd0);
    check("flush_issue_ready", 32'(bus.in_ready), 32'd1);

    // Randomized back-to-back stream
    @(negedge clk);
    pv = 1'b0; pt = 0; pr = '0;
    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 15));
      s1  = int'($urandom_range(0, 7));
      s2  = int'($urandom_range(0, 7));
      tg  = int'($urandom_range(0, 7));
      mt  = int'($urandom_range(0, 7));
      wt  = int'($urandom_range(0, 7));
      ui  = 1'($urandom_range(0, 1));
      imm = W'($urandom);
      r1  = W'($urandom);
      r2  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      mr  = W'($urandom);
      wr  = W'($urandom);
      a_op = ref_fwd(s1, r1, pv, pt, pr, mt, mr, wt, wr);
      b_op = ui ? imm : ref_fwd(s2, r2, pv, pt, pr, mt, mr, wt, wr);
      exp_res = ref_alu(op, a_op, b_op);
      present(op, s1, s2, tg, ui, imm, r1, r2, mt, mr, wt, wr);
      run(res, t, lat, lo);
      check($sformatf("rnd%0d_op%0d_res", i, op), 32'(res), 32'(exp_res));
      check($sformatf("rnd%0d_tgt", i), 32'(t), 32'(tg));
      check($sformatf("rnd%0d_lat", i), 32'(lat), (op >= 7 && op <= 10) ? 32'(W + 1) : 32'd1);
      pv = 1'b1; pt = tg; pr = exp_res;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/execute_mdu.md
# execute_mdu

Parametrised next-generation execute stage for the pipelined CPU. It adds an iterative multiply/divide unit to the single-cycle ALU path, with a valid/ready stall handshake toward decode and operand forwarding from the EX, MEM and WB stages. Width and register-index size are configurable. It sits between decode and memory and drives one registered result per completed instruction.

## Interface
Parameters:
- `WIDTH`, 16, datapath width in bits (≥4, even)
- `REG_BITS`, 3, register index width; index 0 is the hardwired zero register

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage can accept; combinational, `state==IDLE && !rst`
- `flush`  in  1  kill in-flight and presented instruction (branch/halt)
- `alu_op`  in  4  operation, encoding in package
- `use_imm`  in  1  rhs = `imm` instead of forwarded `s_2` operand
- `s_1`, `s_2`, `tgt`  in  REG_BITS  source and target register indices
- `imm`  in  WIDTH  immediate
- `reg_out_1`, `reg_out_2`  in  WIDTH  register-file read data
- `mem_tgt`, `wb_tgt`  in  REG_BITS  later-stage targets (0 = none)
- `mem_result`, `wb_result`  in  WIDTH  later-stage results
- `out_valid`  out  1  result valid, one-cycle pulse
- `out_result`  out  WIDTH  registered result
- `out_tgt`  out  REG_BITS  registered target; 0 when not valid

## Operation
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical, amount = rhs[$clog2(WIDTH)-1:0]), 7 MUL (low WIDTH bits), 8 MULH (high WIDTH bits, unsigned), 9 DIVU, 10 REMU. Codes 11–15 give result 0 and a single cycle.
- Arithmetic is modulo 2^WIDTH. Divide by zero: DIVU returns all-ones, REMU returns the dividend.
- Forwarding per operand, by priority: own `out_tgt` (if `out_valid`), then `mem_tgt`, then `wb_tgt`, then register file. A source index of 0 is never forwarded.
- Operands are sampled only on accept (`in_valid && in_ready && !flush`). Multi-cycle ops run on latched copies.
- FSM `IDLE`/`BUSY`:
  - IDLE, accept single-cycle op: result registered, stay IDLE.
  - IDLE, accept ops 7–10: load the iterator, counter = WIDTH, go to BUSY.
  - BUSY: one bit per cycle (shift-add multiply, restoring divide). Counter decrements. At counter 1, register the result and go to IDLE.
- `flush` in any state: go to IDLE, abort the iterator, accept nothing, and force `out_valid`=0 and `out_tgt`=0 the next cycle.
- `rst` (including mid-operation): `state`=IDLE, `out_valid`=0, `out_result`=0, `out_tgt`=0, counter=0.

## Timing
- Single-cycle op accepted in cycle N → `out_valid` in cycle N+1.
- Multi-cycle op accepted in cycle N → `in_ready` low in cycles N+1..N+WIDTH, `out_valid` in cycle N+WIDTH+1. `in_ready` is high again in N+WIDTH+1, so back-to-back issue is allowed.
- `out_valid` is high for exactly one cycle per completed instruction. There is no downstream backpressure.
- `flush` and `in_valid` in the same cycle: no accept. `flush` in the completion cycle of a BUSY op suppresses the result.

## Structure
- Package `exec_pkg`: `alu_op` enum constants, FSM state enum, divide-by-zero policy constants.
- Sub-module `muldiv_iter` (params WIDTH): start/op/a/b inputs, busy/done/result outputs, plus abort. Holds the product/remainder shift registers and the counter.
- The top level holds the forwarding muxes, the single-cycle ALU, the FSM and the output registers.

## Test plan
- Reset: hold `rst` 2 cycles → `out_valid`=0, `out_tgt`=0, `out_result`=0, `in_ready`=1 once `rst` drops.
- MUL/MULH, WIDTH=16: 300×300 → MUL 0x5F90 and MULH 0x0001. `out_valid` exactly 17 cycles after accept; `in_ready` low in cycles 1–16.
- DIVU/REMU: 100/7 → 14 and 2. Then 0x1234/0 → DIVU 0xFFFF, REMU 0x1234.
- Forwarding: ADD r1=5+3, then back-to-back ADD r2=r1+imm 1 → 9. With `mem_tgt`=`wb_tgt`=3 (0x11 and 0x22), s_1=3 → MEM value 0x11 is used. s_1=0 with `out_tgt`=0 → `reg_out_1` is used.
- Flush/reset mid-MUL: assert `flush` 5 cycles after accept → no `out_valid`, `in_ready`=1 next cycle, and the following ADD completes in 1 cycle. Repeat with `rst` mid-DIVU; all outputs return to reset values.
- Unused code 13 → result 0, single-cycle latency. `flush` together with `in_valid` → nothing accepted and no `out_valid`.
